// File: rtl/key_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : key_state_tracker
// Description : Decodes a PS/2 set-2 byte stream (make, F0 break, E0 extended)
//               into held-level key outputs and a sticky start_game flag.
//               Optional macro KEY_STATE_ARROWS_EN aliases the arrow keys.
// Revision    : 1.0 - initial release
// ============================================================================
module key_state_tracker #(
  parameter logic [7:0] KEY_LEFT       = 8'h1C,
  parameter logic [7:0] KEY_RIGHT      = 8'h23,
  parameter logic [7:0] KEY_UP         = 8'h1D,
  parameter logic [7:0] KEY_DOWN       = 8'h1B,
  parameter logic [7:0] KEY_JUMP       = 8'h29,
  parameter logic [7:0] KEY_START      = 8'h5A,
  parameter int         PREFIX_TIMEOUT = 1_300_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       game_over,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       jump,
  output logic       start_game
);

  localparam logic [7:0]  c_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  c_BREAK_PREFIX = 8'hF0;
  localparam logic [20:0] c_TIMEOUT      = 21'(PREFIX_TIMEOUT);
  localparam logic [20:0] c_CNT_MAX      = 21'h1F_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [20:0] r_cnt;
  logic [20:0] w_cnt_next;
  logic        w_apply;
  logic        w_make;
  logic        w_ext;
  logic        w_is_prefix;

  logic r_left_key, r_right_key, r_up_key, r_down_key, r_jump_key, r_start;

  assign w_is_prefix = (rx_data == c_EXT_PREFIX) || (rx_data == c_BREAK_PREFIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A received byte always takes priority over an expiring prefix timeout.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_apply      = 1'b0;
    w_make       = 1'b0;
    w_ext        = 1'b0;
    if (rx_valid) begin
      w_cnt_next = '0;
      unique case (r_state)
        ST_IDLE: begin
          if (rx_data == c_EXT_PREFIX)        w_state_next = ST_EXT;
          else if (rx_data == c_BREAK_PREFIX) w_state_next = ST_BREAK;
          else begin
            w_apply = 1'b1;
            w_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == c_BREAK_PREFIX)      w_state_next = ST_EXT_BREAK;
          else if (rx_data != c_EXT_PREFIX) begin
            w_apply      = 1'b1;
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_BREAK: begin
          w_apply      = !w_is_prefix;
          w_state_next = ST_IDLE;
        end
        ST_EXT_BREAK: begin
          w_apply      = !w_is_prefix;
          w_ext        = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if (r_state == ST_IDLE) begin
      w_cnt_next = '0;
    end else if (r_cnt == c_TIMEOUT) begin
      w_cnt_next   = '0;
      w_state_next = ST_IDLE;
    end else if (r_cnt != c_CNT_MAX) begin
      w_cnt_next = r_cnt + 21'd1;
    end
  end

  // game_over is evaluated last so it overrides a coincident start make.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left_key  <= 1'b0;
      r_right_key <= 1'b0;
      r_up_key    <= 1'b0;
      r_down_key  <= 1'b0;
      r_jump_key  <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      if (w_apply && !w_ext) begin
        if (rx_data == KEY_LEFT)  r_left_key  <= w_make;
        if (rx_data == KEY_RIGHT) r_right_key <= w_make;
        if (rx_data == KEY_UP)    r_up_key    <= w_make;
        if (rx_data == KEY_DOWN)  r_down_key  <= w_make;
        if (rx_data == KEY_JUMP)  r_jump_key  <= w_make;
        if (rx_data == KEY_START && w_make) r_start <= 1'b1;
      end
      if (game_over) r_start <= 1'b0;
    end
  end

`ifdef KEY_STATE_ARROWS_EN
  localparam logic [7:0] c_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] c_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] c_ARROW_UP    = 8'h75;
  localparam logic [7:0] c_ARROW_DOWN  = 8'h72;

  logic r_left_arw, r_right_arw, r_up_arw, r_down_arw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left_arw  <= 1'b0;
      r_right_arw <= 1'b0;
      r_up_arw    <= 1'b0;
      r_down_arw  <= 1'b0;
    end else if (w_apply && w_ext) begin
      if (rx_data == c_ARROW_LEFT)  r_left_arw  <= w_make;
      if (rx_data == c_ARROW_RIGHT) r_right_arw <= w_make;
      if (rx_data == c_ARROW_UP)    r_up_arw    <= w_make;
      if (rx_data == c_ARROW_DOWN)  r_down_arw  <= w_make;
    end
  end

  assign left  = r_left_key  | r_left_arw;
  assign right = r_right_key | r_right_arw;
  assign up    = r_up_key    | r_up_arw;
  assign down  = r_down_key  | r_down_arw;
`else
  assign left  = r_left_key;
  assign right = r_right_key;
  assign up    = r_up_key;
  assign down  = r_down_key;
`endif

  assign jump       = r_jump_key;
  assign start_game = r_start;

endmodule
`default_nettype wire

// File: tb/tb_key_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_state_tracker
// Description : Directed and random stimulus against a sequence-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_state_tracker;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       game_over = 1'b0;
  logic       left, right, up, down, jump, start_game;

  int checks = 0;
  int errors = 0;

  // Model state: held flags per scan code, pending prefix bytes, idle gap.
  bit  m_key [256];
  bit  m_arw [256];
  bit  m_start;
  byte unsigned m_pend[$];
  int  m_gap;

  key_state_tracker #(.PREFIX_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .game_over(game_over), .left(left), .right(right), .up(up),
    .down(down), .jump(jump), .start_game(start_game)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {left, right, up, down, jump, start_game};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_key[8'h1C] | m_arw[8'h6B], m_key[8'h23] | m_arw[8'h74],
            m_key[8'h1D] | m_arw[8'h75], m_key[8'h1B] | m_arw[8'h72],
            m_key[8'h29], m_start};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_key[i] = 1'b0;
      m_arw[i] = 1'b0;
    end
    m_start = 1'b0;
    m_pend.delete();
    m_gap = 0;
  endtask

  task automatic model_byte(input byte unsigned b);
    bit has_e0, has_f0;
    if (m_pend.size() > 0 && m_gap > T) m_pend.delete();
    m_gap  = 0;
    has_e0 = 1'b0;
    has_f0 = 1'b0;
    foreach (m_pend[i]) begin
      if (m_pend[i] == 8'hE0) has_e0 = 1'b1;
      if (m_pend[i] == 8'hF0) has_f0 = 1'b1;
    end
    if (b == 8'hE0 || b == 8'hF0) begin
      if (has_f0) m_pend.delete();
      else        m_pend.push_back(b);
    end else begin
      if (!has_e0) begin
        m_key[b] = !has_f0;
        if (b == 8'h5A && !has_f0) m_start = 1'b1;
      end
`ifdef KEY_STATE_ARROWS_EN
      else m_arw[b] = !has_f0;
`endif
      m_pend.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // One clock: drive away from the edge, advance the model at the edge, check after.
  task automatic cyc(input bit v, input byte unsigned d, input bit go, input string tag);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    game_over = go;
    @(posedge clk);
    if (v) model_byte(d);
    else if (m_gap < 1000) m_gap++;
    if (go) m_start = 1'b0;
    #1;
    chk(tag, obs(), exp_vec());
  endtask

  task automatic send(input byte unsigned d, input string tag);
    cyc(1'b1, d, 1'b0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, "idle");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    chk("reset_async", obs(), 6'b0);
    @(posedge clk);
    #1;
    chk("reset_hold", obs(), 6'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    byte unsigned pool [13] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h15,
                                8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72};
    model_reset();
    do_reset();
    chk("reset_state", obs(), 6'b0);

    // Reset in the middle of a break sequence discards it.
    send(8'h23, "press_d");
    chk1("press_d_right", right, 1'b1);
    send(8'hF0, "d_break_prefix");
    do_reset();
    send(8'h23, "after_reset_23");
    chk1("no_stale_break", right, 1'b1);
    send(8'hF0, "rel_d_f0");
    send(8'h23, "rel_d");
    chk1("right_released", right, 1'b0);

    // Hold with typematic repeats, then release.
    send(8'h1C, "left_make");
    chk1("left_first", left, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h1C, "left_repeat");
    chk1("left_held", left, 1'b1);
    send(8'hF0, "left_f0");
    chk1("left_before_break", left, 1'b1);
    send(8'h1C, "left_break");
    chk1("left_released", left, 1'b0);

    // Simultaneous keys and unmapped codes.
    send(8'h1C, "sim_1c");
    send(8'h23, "sim_23");
    send(8'h29, "sim_29");
    send(8'hF0, "sim_f0");
    send(8'h23, "sim_rel23");
    send(8'h15, "unmapped_make");
    send(8'hF0, "unmapped_f0");
    send(8'h15, "unmapped_break");
    chk("simultaneous", obs(), 6'b100010);

    // start_game stickiness and game_over precedence.
    send(8'h5A, "start_make");
    chk1("start_set", start_game, 1'b1);
    send(8'hF0, "start_f0");
    send(8'h5A, "start_break");
    chk1("start_sticky", start_game, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, "game_over");
    chk1("start_cleared", start_game, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, "start_vs_game_over");
    chk1("game_over_wins", start_game, 1'b0);

    // Stale break prefix times out; next code is a make.
    send(8'hF0, "timeout_f0");
    idle(T + 2);
    send(8'h1D, "timeout_1d");
    chk1("timeout_make", up, 1'b1);
    send(8'hF0, "up_rel_f0");
    send(8'h1D, "up_rel");

    // Arrow alias held independently of the letter key.
    send(8'hE0, "arw_e0");
    send(8'h75, "arw_75");
`ifdef KEY_STATE_ARROWS_EN
    chk1("arrow_up_make", up, 1'b1);
`else
    chk1("arrow_up_make", up, 1'b0);
`endif
    send(8'h1D, "arw_w");
    send(8'hF0, "arw_w_f0");
    send(8'h1D, "arw_w_rel");
`ifdef KEY_STATE_ARROWS_EN
    chk1("arrow_up_kept", up, 1'b1);
`else
    chk1("arrow_up_kept", up, 1'b0);
`endif
    send(8'hE0, "arw_rel_e0");
    send(8'hF0, "arw_rel_f0");
    send(8'h75, "arw_rel_75");
    chk1("arrow_up_released", up, 1'b0);

    // Random byte stream with occasional long gaps and game_over pulses.
    for (int n = 0; n < 800; n++) begin
      int g;
      byte unsigned b;
      b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0)
                                      : pool[$urandom_range(0, 12)];
      cyc(1'b1, b, ($urandom_range(0, 29) == 0), "random_byte");
      g = ($urandom_range(0, 19) == 0) ? T + 5 : $urandom_range(0, 3);
      idle(g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/key_state_tracker.md
Name: key_state_tracker

Overview:
- Sits directly upstream of the character movement stage.
- Consumes the byte stream from the PS/2 receiver (scan code set 2) and decodes make, break and E0-extended sequences.
- Produces registered, held-level key signals: left, right, jump, up, down, start_game.
- The movement stage consumes these as levels. It applies its own priority and start_game/animation gating, so this block does no gating.

Parameters:
- KEY_LEFT, 8'h1C, code for A (left)
- KEY_RIGHT, 8'h23, code for D (right)
- KEY_UP, 8'h1D, code for W (ladder up)
- KEY_DOWN, 8'h1B, code for S (ladder down)
- KEY_JUMP, 8'h29, code for Space (jump)
- KEY_START, 8'h5A, code for Enter (start game)
- PREFIX_TIMEOUT, 1_300_000, clk cycles allowed between prefix byte and code byte (~20 ms at 65 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received PS/2 byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe, one per received byte
- game_over  in  1  level; clears start_game
- left  out  1  left key held
- right  out  1  right key held
- up  out  1  up key held
- down  out  1  down key held
- jump  out  1  jump key held
- start_game  out  1  sticky; set by Enter make, cleared by game_over

Behaviour:
- Reset, asynchronous and active-high:
  - All outputs 0.
  - FSM returns to ST_IDLE.
  - Timeout counter cleared.
  - Takes effect immediately, including mid-sequence. A partially received sequence is discarded.
- FSM states and transitions, evaluated only on rx_valid:
  - ST_IDLE: E0 -> ST_EXT; F0 -> ST_BREAK; any other byte = make code, apply, stay.
  - ST_EXT: F0 -> ST_EXT_BREAK; E0 -> stay; other byte = extended make, apply, -> ST_IDLE.
  - ST_BREAK: any byte other than E0/F0 = break code, apply, -> ST_IDLE. E0/F0 in this state is malformed: -> ST_IDLE, no output change.
  - ST_EXT_BREAK: non-prefix byte = extended break, apply, -> ST_IDLE. E0/F0 -> ST_IDLE, no change.
- Applying a code:
  - Make of a mapped key sets its held bit to 1.
  - Break clears it to 0.
  - Unmapped codes are ignored (no output change, FSM still advances).
  - Repeated makes (typematic) are idempotent.
- start_game:
  - Set to 1 on KEY_START make.
  - KEY_START break has no effect.
  - Cleared while game_over=1.
  - If game_over=1 coincides with a start make, game_over wins (start_game=0).
- Latency: every output changes on the clk edge that samples the rx_valid of the final byte of a sequence, i.e. visible the cycle after that strobe.
- Simultaneous keys: each bit is tracked independently. Left and right may both be 1; the downstream priority resolves this.
- Prefix timeout:
  - In ST_EXT, ST_BREAK or ST_EXT_BREAK, a 21-bit counter increments each cycle without rx_valid.
  - When it reaches PREFIX_TIMEOUT the FSM returns to ST_IDLE with no output change.
  - The counter clears on every rx_valid and in ST_IDLE. It saturates and never wraps.
- Bytes arriving on consecutive cycles are each processed. No byte is dropped.

Optional Feature:
- Macro: KEY_STATE_ARROWS_EN.
- Defined:
  - Extended codes E0 6B / E0 74 / E0 75 / E0 72 are aliased to left / right / up / down respectively.
  - Each output is the OR of its letter-key bit and its arrow-key bit, tracked separately, so releasing A does not clear a still-held left arrow.
  - The arrow bits reset to 0 with the other state.
- Not defined: every E0-prefixed make or break is ignored. The FSM still walks ST_EXT/ST_EXT_BREAK to consume the sequence. Outputs derive from letter keys only.

Test Plan:
- Reset mid-sequence: press D (23), send F0, assert rst, release, send 23 -> right=1 after the 23 byte, no stale break applied; all outputs 0 during reset.
- Hold and release: 1C, repeated 1C x3, F0 1C -> left=1 the cycle after the first 1C strobe, stays 1 through the repeats, 0 the cycle after the final 1C.
- Simultaneous: 1C, 23, 29, F0 23 -> left=1, jump=1, right=0 at the end; unmapped 15 and F0 15 cause no change.
- start_game: 5A -> start_game=1; F0 5A -> stays 1; game_over pulse -> 0; 5A sent in the same cycle as game_over=1 -> 0.
- Timeout: send F0, wait PREFIX_TIMEOUT+2 cycles, send 1D -> treated as make, up=1.
- Arrows, with KEY_STATE_ARROWS_EN: E0 75 -> up=1; 1D, F0 1D -> up stays 1; E0 F0 75 -> up=0. Without the macro the same arrow stream leaves up=0 throughout.
